// File: rtl/tow_pkg.sv
// Shared Tug of War definitions: LFSR width and the computer-player state encoding.
package tow_pkg;

    localparam int unsigned LFSR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        PRESS,
        HOLD
    } cpu_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running sample divider: tick marks the last cycle of every DIV-cycle period while en is high.
module tick_gen #(
    parameter int unsigned DIV = 8
) (
    input  logic clk,
    input  logic r,
    input  logic en,
    output logic tick
);

    localparam int unsigned   TW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_tcnt <= '0;
        end else if (!en || (r_tcnt == LAST)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign tick = en && (r_tcnt == LAST);

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: samples LFSR against difficulty on each tick and emits
// a single-cycle press followed by a HOLDOFF-cycle lockout.
module cpu_player
    import tow_pkg::*;
#(
    parameter int unsigned W       = LFSR_W,
    parameter int unsigned DIV     = 8,
    parameter int unsigned HOLDOFF = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         en,
    input  logic [W-1:0] rnd,
    input  logic [W-2:0] level,
    output logic         press,
    output logic         busy,
    output logic [7:0]   count
);

    localparam int unsigned   HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    cpu_state_t    r_state;
    cpu_state_t    w_next;
    logic [HW-1:0] r_hcnt;
    logic [7:0]    r_count;
    logic          w_tick;
    logic          w_hit;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .r    (r),
        .en   (en),
        .tick (w_tick)
    );

    // level is one bit narrower than rnd, so level can never equal 2^W-1 and never ties above
    assign w_hit = ({1'b0, level} > rnd);

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = SAMPLE;
                SAMPLE:  if (w_tick && w_hit) w_next = PRESS;
                PRESS:   w_next = HOLD;
                HOLD:    if (r_hcnt == '0) w_next = SAMPLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_hcnt <= '0;
        end else if (r_state == PRESS) begin
            r_hcnt <= HOLD_LAST;
        end else if ((r_state == HOLD) && (r_hcnt != '0)) begin
            r_hcnt <= r_hcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_count <= '0;
        end else if ((r_state == PRESS) && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign press = (r_state == PRESS);
    assign busy  = (r_state == HOLD);
    assign count = r_count;

endmodule

// File: tb/tb_cpu_player.sv
// Directed self-checking bench for cpu_player with DIV=8, HOLDOFF=4.
module tb_cpu_player;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic       en  = 1'b0;
    logic [9:0] rnd = '0;
    logic [8:0] level = '0;
    logic       press;
    logic       busy;
    logic [7:0] count;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    cpu_player #(
        .W       (10),
        .DIV     (8),
        .HOLDOFF (4)
    ) dut (
        .clk   (clk),
        .r     (r),
        .en    (en),
        .rnd   (rnd),
        .level (level),
        .press (press),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fresh start with en=1: after this, edge n gives tcnt = n mod 8,
    // so with a hit the press is visible right after edges 8, 16, ...
    task automatic restart();
        en = 1'b1;
        r  = 1'b1;
        step();
        r  = 1'b0;
    endtask

    int unsigned seen;

    initial begin
        // Reset held for 3 cycles with a stimulus that would otherwise press
        en = 1'b1; level = 9'd511; rnd = 10'd0; r = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_press", press, 0);
            chk("rst_busy",  busy,  0);
            chk("rst_count", count, 0);
            step();
        end

        // level=0 never hits
        level = 9'd0; rnd = 10'd0;
        restart();
        seen = 0;
        for (int n = 1; n <= 80; n++) begin
            step();
            if (press) seen++;
        end
        chk("never_presses", seen, 0);
        chk("never_count",   count, 0);

        // Always hit: press every 8 edges, busy the 4 cycles after each press
        level = 9'd511; rnd = 10'd100;
        restart();
        for (int n = 1; n <= 81; n++) begin
            step();
            chk("always_press", press, ((n % 8) == 0) ? 1 : 0);
            chk("always_busy",  busy,  ((n >= 9) && ((n % 8) >= 1) && ((n % 8) <= 4)) ? 1 : 0);
            chk("always_count", count, (n - 1) / 8);
        end
        chk("always_count10", count, 10);

        // Compare boundary at level=300
        level = 9'd300; rnd = 10'd300;
        restart();
        seen = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (press) seen++;
        end
        chk("equal_miss", seen, 0);
        rnd  = 10'd299;
        seen = 0;
        for (int n = 9; n <= 15; n++) begin
            step();
            if (press) seen++;
        end
        chk("below_early", seen, 0);
        step();
        chk("below_hit", press, 1);
        rnd  = 10'd1023;
        seen = 0;
        for (int n = 17; n <= 32; n++) begin
            step();
            if (press) seen++;
        end
        chk("max_rnd_miss", seen, 0);
        chk("boundary_count", count, 1);

        // en dropped on the 2nd busy cycle, then re-raised
        level = 9'd511; rnd = 10'd100;
        restart();
        for (int n = 1; n <= 10; n++) step();
        chk("drop_busy2", busy, 1);
        en = 1'b0;
        step();
        chk("drop_busy_clr", busy,  0);
        chk("drop_press",    press, 0);
        en   = 1'b1;
        seen = 0;
        // counting the IDLE edge as the first, the press follows the 9th edge
        for (int k = 2; k <= 8; k++) begin
            step();
            if (press || busy) seen++;
        end
        chk("reen_quiet", seen, 0);
        step();
        chk("reen_press", press, 1);

        // Saturation at 255 while presses keep pulsing
        restart();
        seen = 0;
        for (int n = 1; n <= 2401; n++) begin
            step();
            if (press) seen++;
        end
        chk("sat_presses", seen, 300);
        chk("sat_count",   count, 255);
        for (int n = 2402; n <= 2408; n++) step();
        chk("sat_press_pulse", press, 1);
        chk("sat_count_hold",  count, 255);

        // Asynchronous reset in the middle of a PRESS cycle
        #2;
        r = 1'b1;
        #1;
        chk("async_press", press, 0);
        chk("async_count", count, 0);
        chk("async_busy",  busy,  0);
        step();
        r = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
